// File: rtl/toast_prefetch_unit_if.sv
// Purpose: bundles the redirect, ID-side and imem-side signals of the Toast prefetch unit.
// Latency: none, this is wiring only.
// Backpressure: carries if_ready (ID stall) and imem_gnt (memory stall) back to the prefetch unit.
interface toast_prefetch_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            if_valid;
   logic            if_ready;
   logic [31:0]     if_instruction;
   logic [XLEN-1:0] if_pc;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [31:0]     imem_rdata;

   // Prefetch unit side.
   modport slave (
      input  redirect_valid, redirect_pc, if_ready, imem_gnt, imem_rvalid, imem_rdata,
      output if_valid, if_instruction, if_pc, imem_req, imem_addr
   );

   // Pipeline/memory environment side.
   modport master (
      output redirect_valid, redirect_pc, if_ready, imem_gnt, imem_rvalid, imem_rdata,
      input  if_valid, if_instruction, if_pc, imem_req, imem_addr
   );
endinterface

// File: rtl/toast_prefetch_unit.sv
// Purpose: sequential instruction prefetch into a DEPTH-entry {pc, instr} buffer, with redirect flush/squash.
// Latency: redirect -> IF valid in 3 cycles; 2 cycles when TOAST_PF_BYPASS_EN routes rdata straight to IF.
// Backpressure: fetches are credit-limited (buffered + in flight <= DEPTH); if_ready low holds the head stable.
module toast_prefetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   toast_prefetch_unit_if.slave  io_pf
);
   localparam int unsigned     CW      = $clog2(DEPTH + 1);
   localparam int unsigned     PW      = $clog2(DEPTH);
   localparam logic [CW:0]     W_DEPTH = (CW + 1)'(DEPTH);
   localparam logic [XLEN-1:0] W_RPC   = {RESET_PC[XLEN-1:2], 2'b00};
   localparam logic [XLEN-1:0] W_FOUR  = XLEN'(4);

   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_resp_pc;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   r_outst;
   logic [CW-1:0]   r_discard;
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [XLEN-1:0] r_mem_pc  [DEPTH];
   logic [31:0]     r_mem_ins [DEPTH];

   logic [CW:0]     w_used;
   logic            w_req;
   logic            w_gnt;
   logic            w_empty;
   logic            w_live;
   logic            w_byp;
   logic            w_valid;
   logic            w_pop;
   logic            w_push;
   logic [CW-1:0]   w_outst_nxt;
   logic [XLEN-1:0] w_redir_pc;

   assign w_used      = {1'b0, r_count} + {1'b0, r_outst};
   assign w_req       = !i_rst && !io_pf.redirect_valid && (w_used < W_DEPTH);
   assign w_gnt       = w_req && io_pf.imem_gnt;
   assign w_empty     = (r_count == '0);
   // A response is live only once every pre-redirect response has drained.
   assign w_live      = io_pf.imem_rvalid && (r_discard == '0) && !io_pf.redirect_valid;
   assign w_outst_nxt = r_outst + CW'(w_gnt) - CW'(io_pf.imem_rvalid);
   assign w_redir_pc  = {io_pf.redirect_pc[XLEN-1:2], 2'b00};

`ifdef TOAST_PF_BYPASS_EN
   assign w_byp = w_empty && (r_discard == '0) && io_pf.imem_rvalid;
`else
   assign w_byp = 1'b0;
`endif

   assign w_valid = !i_rst && (!w_empty || w_byp) && !io_pf.redirect_valid;
   assign w_pop   = w_valid && io_pf.if_ready && !w_empty;
   // A bypassed word taken by ID in its arrival cycle never enters the buffer.
   assign w_push  = w_live && !(w_byp && io_pf.if_ready);

   assign io_pf.imem_req  = w_req;
   assign io_pf.imem_addr = r_fetch_pc;
   assign io_pf.if_valid  = w_valid;

`ifdef TOAST_PF_BYPASS_EN
   assign io_pf.if_instruction = w_byp ? io_pf.imem_rdata : r_mem_ins[r_rd_ptr];
   assign io_pf.if_pc          = w_byp ? r_resp_pc        : r_mem_pc[r_rd_ptr];
`else
   assign io_pf.if_instruction = r_mem_ins[r_rd_ptr];
   assign io_pf.if_pc          = r_mem_pc[r_rd_ptr];
`endif

   // PCs, pointers and credit counters; a redirect flushes the buffer and squashes what is in flight.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fetch_pc <= W_RPC;
         r_resp_pc  <= W_RPC;
         r_count    <= '0;
         r_outst    <= '0;
         r_discard  <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
      end else if (io_pf.redirect_valid) begin
         r_fetch_pc <= w_redir_pc;
         r_resp_pc  <= w_redir_pc;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_outst    <= w_outst_nxt;
         r_discard  <= w_outst_nxt;
      end else begin
         if (w_gnt) begin
            r_fetch_pc <= r_fetch_pc + W_FOUR;
         end
         r_outst <= w_outst_nxt;
         if (io_pf.imem_rvalid && (r_discard != '0)) begin
            r_discard <= r_discard - CW'(1);
         end
         if (w_live) begin
            r_resp_pc <= r_resp_pc + W_FOUR;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Buffer storage; cleared on reset so the IF outputs read zero until the first word lands.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem_pc[i]  <= '0;
            r_mem_ins[i] <= '0;
         end
      end else if (w_push) begin
         r_mem_pc[r_wr_ptr]  <= r_resp_pc;
         r_mem_ins[r_wr_ptr] <= io_pf.imem_rdata;
      end
   end

   // Overflow or a discard count above the in-flight count means the credit accounting is broken.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         assert (!(w_push && (r_count == CW'(DEPTH))));
         assert (r_discard <= r_outst);
      end
   end
endmodule

// File: tb/tb_toast_prefetch_unit.sv
module tb_toast_prefetch_unit;
   localparam int          XLEN  = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h100;
`ifdef TOAST_PF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic [31:0] addr;
      int          ep;
      int          due;
   } mreq_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   toast_prefetch_unit_if #(.XLEN(XLEN)) bus ();

   toast_prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .io_pf (bus)
   );

   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          buffered = 0;
   int          first_v = -1;
   logic [31:0] exp_fetch;
   logic [31:0] exp_del;
   mreq_t       mq [$];
   logic [31:0] glog [$];
   logic [31:0] dlog [$];

   // Instruction memory contents as a pure function of the address.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic logic [31:0] qget(input logic [31:0] q [$], input int i);
      return (q.size() > i) ? q[i] : 32'hDEAD_DEAD;
   endfunction

   // One clock cycle: drive inputs, compare DUT outputs with the model, then advance the model.
   task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy,
                       input logic gnt, input int dly);
      logic  kept, exp_req, exp_v;
      mreq_t h;
      @(negedge clk);
      cyc++;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      bus.if_ready       = rdy;
      bus.imem_gnt       = gnt;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = memf(mq[0].addr);
      end else begin
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = $urandom;
      end
      #2;
      kept    = bus.imem_rvalid && !redir && (mq.size() > 0) && (mq[0].ep == epoch);
      exp_req = !redir && (mq.size() + buffered < DEPTH);
      exp_v   = !redir && (buffered > 0 || (BYP && kept));
      chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
      chk("if_valid", 32'(bus.if_valid), 32'(exp_v));
      if (exp_req) chk("imem_addr", bus.imem_addr, exp_fetch);
      if (exp_v) begin
         chk("if_pc", bus.if_pc, exp_del);
         chk("if_instruction", bus.if_instruction, memf(exp_del));
      end
      if (bus.if_valid === 1'b1 && first_v < 0) first_v = cyc;
      if (bus.imem_req === 1'b1 && gnt) glog.push_back(bus.imem_addr);
      if (redir) begin
         if (bus.imem_rvalid) void'(mq.pop_front());
         epoch++;
         exp_fetch = {rpc[31:2], 2'b00};
         exp_del   = {rpc[31:2], 2'b00};
         buffered  = 0;
      end else begin
         if (exp_req && gnt) begin
            h.addr = exp_fetch;
            h.ep   = epoch;
            h.due  = cyc + 1 + ((dly < 0) ? int'($urandom_range(0, 3)) : dly);
            mq.push_back(h);
            exp_fetch = exp_fetch + 32'd4;
         end
         if (bus.imem_rvalid) void'(mq.pop_front());
         if (kept) buffered++;
         if (exp_v && rdy) begin
            dlog.push_back(bus.if_pc);
            buffered--;
            exp_del = exp_del + 32'd4;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.if_ready       = 1'b0;
      bus.imem_gnt       = 1'b0;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
      chk("rst_if_instruction", bus.if_instruction, 32'd0);
      chk("rst_if_pc", bus.if_pc, 32'd0);
      chk("rst_addr", bus.imem_addr, 32'h100);
      rst       = 1'b0;
      exp_fetch = RPC;
      exp_del   = RPC;

      // Streaming from reset with a 1-cycle memory.
      cyc = 0;
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1, 0);
      chk("first_valid_cycle", 32'(first_v), BYP ? 32'd2 : 32'd3);
      chk("addr0", qget(glog, 0), 32'h100);
      chk("addr1", qget(glog, 1), 32'h104);
      chk("addr2", qget(glog, 2), 32'h108);
      chk("pc0", qget(dlog, 0), 32'h100);
      chk("pc1", qget(dlog, 1), 32'h104);

      // Stall: only DEPTH fetches may be granted, then in-order release.
      step(1'b1, 32'h100, 1'b1, 1'b1, 0);
      glog.delete();
      dlog.delete();
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1, 0);
      chk("stall_grants", 32'(glog.size()), 32'd4);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1, 0);
      for (int i = 0; i < 4; i++) chk("release_pc", qget(dlog, i), 32'h100 + 32'(4 * i));

      // Two slow fetches in flight are squashed by a redirect.
      step(1'b1, 32'h200, 1'b1, 1'b1, 0);
      step(1'b0, '0, 1'b1, 1'b1, 3);
      step(1'b0, '0, 1'b1, 1'b1, 3);
      dlog.delete();
      step(1'b1, 32'h400, 1'b1, 1'b1, 0);
      for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b1, 0);
      chk("squash_pc0", qget(dlog, 0), 32'h400);
      chk("squash_pc1", qget(dlog, 1), 32'h404);

      // Redirect while a response arrives, then a second redirect the next cycle.
      step(1'b1, 32'h500, 1'b1, 1'b1, 0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1, 0);
      dlog.delete();
      step(1'b1, 32'h600, 1'b1, 1'b1, 0);
      step(1'b1, 32'h800, 1'b1, 1'b1, 0);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1, 0);
      chk("double_redir_pc0", qget(dlog, 0), 32'h800);
      step(1'b1, 32'h900, 1'b0, 1'b1, 0);
      glog.delete();
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1, 0);
      chk("credit_restored", 32'(glog.size()), 32'd4);

      // Address wrap; the unaligned target is forced to a word boundary.
      glog.delete();
      step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
      dlog.delete();
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1, 0);
      chk("wrap_addr0", qget(glog, 0), 32'hFFFF_FFFC);
      chk("wrap_addr1", qget(glog, 1), 32'h0000_0000);
      chk("wrap_pc0", qget(dlog, 0), 32'hFFFF_FFFC);
      chk("wrap_pc1", qget(dlog, 1), 32'h0000_0000);

      // Random grant/response delays, stalls and redirects.
      for (int i = 0; i < 10000; i++) begin
         logic        r;
         logic [31:0] pc;
         r  = ($urandom_range(0, 49) == 0);
         pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                          : ($urandom & 32'h0000_FFFF);
         step(r, pc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
